// File: rtl/bakraid_pcm_arb_if.sv
// rtl/bakraid_pcm_arb_if.sv - requester and PCM slot signals of the sample-ROM arbiter
interface bakraid_pcm_arb_if;
    logic        REQ;
    logic [23:0] ADDR;
    logic [7:0]  DOUT;
    logic        VALID;
    logic        INVAL;
    logic        BUSY;
    logic        TMO;
    logic        PCM0_CS;
    logic        PCM1_CS;
    logic        PCM2_CS;
    logic [21:0] PCM0_ADDR;
    logic [21:0] PCM1_ADDR;
    logic [21:0] PCM2_ADDR;
    logic        PCM0_OK;
    logic        PCM1_OK;
    logic        PCM2_OK;
    logic [7:0]  PCM0_DOUT;
    logic [7:0]  PCM1_DOUT;
    logic [7:0]  PCM2_DOUT;

    modport slave (
        input  REQ, ADDR, INVAL,
        input  PCM0_OK, PCM1_OK, PCM2_OK,
        input  PCM0_DOUT, PCM1_DOUT, PCM2_DOUT,
        output DOUT, VALID, BUSY, TMO,
        output PCM0_CS, PCM1_CS, PCM2_CS,
        output PCM0_ADDR, PCM1_ADDR, PCM2_ADDR
    );

    modport master (
        output REQ, ADDR, INVAL,
        output PCM0_OK, PCM1_OK, PCM2_OK,
        output PCM0_DOUT, PCM1_DOUT, PCM2_DOUT,
        input  DOUT, VALID, BUSY, TMO,
        input  PCM0_CS, PCM1_CS, PCM2_CS,
        input  PCM0_ADDR, PCM1_ADDR, PCM2_ADDR
    );
endinterface

// File: rtl/bakraid_pcm_arb.sv
// rtl/bakraid_pcm_arb.sv - YMZ280B byte fetch sequencer over three PCM SDRAM banks
module bakraid_pcm_arb #(
    parameter int TIMEOUT  = 255,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    bakraid_pcm_arb_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GUARD, FETCH, DONE} state_t;

    localparam logic [15:0] TMO_LIM = 16'(TIMEOUT);

    state_t      state;
    logic [23:0] areg;
    logic [1:0]  bank;
    logic [15:0] cnt;
    logic [23:0] ctag;
    logic [7:0]  cdata;
    logic        cvalid;
    logic        nofill;
    logic [7:0]  dout_r;
    logic        valid_r;
    logic        tmo_r;
    logic [2:0]  cs_r;
    logic [21:0] a0, a1, a2;

    logic        sel_ok;
    logic [7:0]  sel_dout;
    logic        hit;

    always_comb begin
        sel_ok   = 1'b0;
        sel_dout = 8'h00;
        case (bank)
            2'd0: begin sel_ok = bus.PCM0_OK; sel_dout = bus.PCM0_DOUT; end
            2'd1: begin sel_ok = bus.PCM1_OK; sel_dout = bus.PCM1_DOUT; end
            2'd2: begin sel_ok = bus.PCM2_OK; sel_dout = bus.PCM2_DOUT; end
            default: ;
        endcase
    end

    assign hit = CACHE_EN && cvalid && (bus.ADDR == ctag);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            areg    <= '0;
            bank    <= '0;
            cnt     <= '0;
            ctag    <= '0;
            cdata   <= '0;
            cvalid  <= 1'b0;
            nofill  <= 1'b0;
            dout_r  <= '0;
            valid_r <= 1'b0;
            tmo_r   <= 1'b0;
            cs_r    <= '0;
            a0      <= '0;
            a1      <= '0;
            a2      <= '0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.REQ) begin
                        areg <= bus.ADDR;
                        bank <= bus.ADDR[23:22];
                        if (bus.ADDR[23:22] == 2'd3) begin
                            dout_r  <= 8'h00;
                            valid_r <= 1'b1;
                            state   <= DONE;
                        end else if (hit) begin
                            dout_r  <= cdata;
                            valid_r <= 1'b1;
                            state   <= DONE;
                        end else begin
                            cs_r   <= 3'b001 << bus.ADDR[23:22];
                            case (bus.ADDR[23:22])
                                2'd0:    a0 <= bus.ADDR[21:0];
                                2'd1:    a1 <= bus.ADDR[21:0];
                                default: a2 <= bus.ADDR[21:0];
                            endcase
                            cnt    <= '0;
                            nofill <= 1'b0;
                            state  <= GUARD;
                        end
                    end
                end
                GUARD: begin
                    // OK may still belong to the slot's previous address; count but don't look.
                    cnt   <= (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
                    state <= FETCH;
                end
                FETCH: begin
                    if (sel_ok) begin
                        dout_r  <= sel_dout;
                        valid_r <= 1'b1;
                        cs_r    <= '0;
                        state   <= DONE;
                        if (!nofill && !bus.INVAL) begin
                            ctag   <= areg;
                            cdata  <= sel_dout;
                            cvalid <= 1'b1;
                        end
                    end else if (cnt >= TMO_LIM) begin
                        dout_r  <= 8'h00;
                        tmo_r   <= 1'b1;
                        valid_r <= 1'b1;
                        cs_r    <= '0;
                        state   <= DONE;
                    end else begin
                        cnt <= (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Invalidate wins over any same-cycle fill or timeout, and poisons an in-flight fetch.
            if (bus.INVAL) begin
                cvalid <= 1'b0;
                tmo_r  <= 1'b0;
                nofill <= 1'b1;
            end
        end
    end

    assign bus.DOUT      = dout_r;
    assign bus.VALID     = valid_r;
    assign bus.BUSY      = (state != IDLE);
    assign bus.TMO       = tmo_r;
    assign bus.PCM0_CS   = cs_r[0];
    assign bus.PCM1_CS   = cs_r[1];
    assign bus.PCM2_CS   = cs_r[2];
    assign bus.PCM0_ADDR = a0;
    assign bus.PCM1_ADDR = a1;
    assign bus.PCM2_ADDR = a2;
endmodule

// File: tb/tb_bakraid_pcm_arb.sv
// tb/tb_bakraid_pcm_arb.sv - vector table, directed sequences and randomized model check
module tb_bakraid_pcm_arb;
    localparam int T = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bakraid_pcm_arb_if bus();

    bakraid_pcm_arb #(.TIMEOUT(T), .CACHE_EN(1'b1)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic        m_cvalid = 1'b0;
    logic [23:0] m_ctag   = '0;
    logic [7:0]  m_cdata  = '0;
    logic        m_tmo    = 1'b0;

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  data;
        int          d;
        bit          stale;
        bit          held;
        int          exp_n;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic get_cs(input int b);
        case (b)
            0: return bus.PCM0_CS;
            1: return bus.PCM1_CS;
            default: return bus.PCM2_CS;
        endcase
    endfunction

    function automatic logic [21:0] get_addr(input int b);
        case (b)
            0: return bus.PCM0_ADDR;
            1: return bus.PCM1_ADDR;
            default: return bus.PCM2_ADDR;
        endcase
    endfunction

    task automatic set_slot(input int b, input logic ok, input logic [7:0] dv);
        case (b)
            0: begin bus.PCM0_OK = ok; bus.PCM0_DOUT = dv; end
            1: begin bus.PCM1_OK = ok; bus.PCM1_DOUT = dv; end
            default: begin bus.PCM2_OK = ok; bus.PCM2_DOUT = dv; end
        endcase
    endtask

    // kind: 0 out of range, 1 cache hit, 2 miss answered, 3 miss timed out.
    // n: edges after the accept edge at which VALID is registered.
    function automatic void predict(input logic [23:0] addr, input logic [7:0] data, input int d,
                                    output int kind, output int n, output logic [7:0] dv);
        if (addr[23:22] == 2'd3) begin
            kind = 0; n = 0; dv = 8'h00;
        end else if (m_cvalid && addr == m_ctag) begin
            kind = 1; n = 0; dv = m_cdata;
        end else if (d <= T - 1) begin
            kind = 2; n = 2 + d; dv = data;
        end else begin
            kind = 3; n = 1 + T; dv = 8'h00;
        end
    endfunction

    task automatic wait_idle();
        int w = 0;
        while (bus.BUSY !== 1'b0 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (w == 50) check("idle_wait", 32'(bus.BUSY), 32'd0);
    endtask

    task automatic run_req(input logic [23:0] addr, input logic [7:0] data, input int d,
                           input bit stale, input bit held, input int inv_n,
                           input int exp_n, input logic [7:0] exp_dout);
        int kind, pn, b;
        logic [7:0] pd;
        bit miss, got, tmo_ev;
        logic exp_tmo;
        predict(addr, data, d, kind, pn, pd);
        miss   = (kind >= 2);
        tmo_ev = (kind == 3);
        b      = int'(addr[23:22]);
        if (miss) begin
            if (inv_n >= 0) begin
                m_cvalid = 1'b0;
                m_tmo    = tmo_ev && (inv_n + 1 < pn);
            end else if (tmo_ev) begin
                m_tmo = 1'b1;
            end else begin
                m_cvalid = 1'b1; m_ctag = addr; m_cdata = data;
            end
        end
        exp_tmo = m_tmo;

        wait_idle();
        bus.REQ  = 1'b1;
        bus.ADDR = addr;
        if (miss && stale) set_slot(b, 1'b1, 8'h00);
        got = 1'b0;
        for (int n = 0; n <= 24 && !got; n++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++)
                check($sformatf("cs%0d_n%0d", i, n), 32'(get_cs(i)),
                      32'(miss && i == b && n < pn));
            if (miss && n == 0) check("pcm_addr", 32'(get_addr(b)), 32'(addr[21:0]));
            if (bus.VALID === 1'b1) begin
                got = 1'b1;
                check("latency", 32'(n), 32'(exp_n));
                check("dout", 32'(bus.DOUT), 32'(exp_dout));
                check("tmo", 32'(bus.TMO), 32'(exp_tmo));
            end
            bus.INVAL = (n == inv_n);
            for (int i = 0; i < 3; i++) begin
                if (miss && i == b)
                    set_slot(i, (stale && n < 1) || (n >= 1 + d),
                             (n >= 1 + d) ? data : (stale ? 8'h00 : 8'($urandom)));
                else
                    set_slot(i, 1'($urandom), 8'($urandom));
            end
        end
        if (!got) check("no_valid", 32'd0, 32'd1);
        bus.INVAL = 1'b0;
        if (!held) bus.REQ = 1'b0;
        @(posedge clk); #1;
        check("valid_pulse", 32'(bus.VALID), 32'd0);
        check("done_no_reaccept", 32'(bus.BUSY), 32'd0);
        check("cs_idle", 32'({bus.PCM2_CS, bus.PCM1_CS, bus.PCM0_CS}), 32'd0);
        bus.REQ = 1'b0;
        for (int i = 0; i < 3; i++) set_slot(i, 1'b0, 8'h00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, pn, d, inv_n;
        logic [7:0] pd, data;
        logic [23:0] addr, last_addr;
        bit stale;

        tbl[0] = '{24'h012345, 8'hA5, 2, 1'b0, 1'b0, 4, 8'hA5};
        tbl[1] = '{24'h012345, 8'hA5, 0, 1'b0, 1'b1, 0, 8'hA5};
        tbl[2] = '{24'h400010, 8'h11, 0, 1'b0, 1'b0, 2, 8'h11};
        tbl[3] = '{24'h8FFFFF, 8'h22, 1, 1'b0, 1'b1, 3, 8'h22};
        tbl[4] = '{24'h000100, 8'h5A, 0, 1'b1, 1'b0, 2, 8'h5A};
        tbl[5] = '{24'hC00000, 8'h00, 0, 1'b0, 1'b1, 0, 8'h00};
        tbl[6] = '{24'h000200, 8'h99, 9, 1'b0, 1'b0, 5, 8'h00};
        tbl[7] = '{24'h000100, 8'h00, 0, 1'b0, 1'b0, 0, 8'h5A};

        bus.REQ = 1'b0; bus.ADDR = '0; bus.INVAL = 1'b0;
        for (int i = 0; i < 3; i++) set_slot(i, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", 32'(bus.DOUT), 32'd0);
        check("rst_valid", 32'(bus.VALID), 32'd0);
        check("rst_cs", 32'({bus.PCM2_CS, bus.PCM1_CS, bus.PCM0_CS}), 32'd0);
        check("rst_addr", 32'(bus.PCM0_ADDR | bus.PCM1_ADDR | bus.PCM2_ADDR), 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_tmo", 32'(bus.TMO), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++)
            run_req(tbl[v].addr, tbl[v].data, tbl[v].d, tbl[v].stale, tbl[v].held, -1,
                    tbl[v].exp_n, tbl[v].exp_dout);

        // INVAL clears the sticky timeout flag and the cache
        bus.INVAL = 1'b1;
        @(posedge clk); #1;
        bus.INVAL = 1'b0;
        check("inval_tmo", 32'(bus.TMO), 32'd0);
        m_tmo = 1'b0; m_cvalid = 1'b0;
        run_req(24'h000100, 8'h5A, 0, 1'b0, 1'b0, -1, 2, 8'h5A);

        // reset during a bank 2 fetch; the cached address must miss afterwards
        run_req(24'h800040, 8'h77, 0, 1'b0, 1'b0, -1, 2, 8'h77);
        bus.REQ = 1'b1; bus.ADDR = 24'h800080;
        @(posedge clk); #1;
        check("rst_mid_cs_before", 32'(bus.PCM2_CS), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_cs", 32'(bus.PCM2_CS), 32'd0);
        check("rst_mid_valid", 32'(bus.VALID), 32'd0);
        check("rst_mid_busy", 32'(bus.BUSY), 32'd0);
        bus.REQ = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_cvalid = 1'b0; m_tmo = 1'b0;
        @(posedge clk); #1;
        run_req(24'h800040, 8'h77, 1, 1'b0, 1'b0, -1, 3, 8'h77);

        last_addr = 24'h800040;
        for (int r = 0; r < 80; r++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: addr = last_addr;
                3:       addr = {2'b11, 22'($urandom)};
                default: addr = {2'($urandom_range(0, 2)), 22'($urandom)};
            endcase
            data  = addr[7:0] ^ addr[15:8] ^ addr[23:16] ^ 8'h3C;
            d     = $urandom_range(0, 6);
            stale = (d < T) && ($urandom_range(0, 3) == 0);
            predict(addr, data, d, kind, pn, pd);
            inv_n = (kind >= 2 && $urandom_range(0, 7) == 0) ? $urandom_range(0, pn - 1) : -1;
            run_req(addr, data, d, stale, 1'($urandom), inv_n, pn, pd);
            if (addr[23:22] != 2'd3) last_addr = addr;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
